ram_read_streamer: RTL and testbench

Single-clock burst reader that sits directly downstream of the dual-port RAM's read port. On a start command it drives `address_read` through `length` consecutive addresses (wrapping modulo the depth) and captures the RAM's registered `data_read`. It delivers the words as a valid/ready stream with `m_last` on the final word. A 2-entry output buffer absorbs backpressure so no RAM word is lost or read twice.

---
 rtl/ram_read_streamer.sv | 175 +++++++++++++++++
 tb/tb_ram_read_streamer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_streamer.sv
// ram_read_streamer: burst reader for the read port of a dual-port RAM.
// On an accepted start it walks length consecutive addresses (wrapping at
// the RAM depth), captures the registered RAM output one cycle later and
// presents the words as a valid/ready stream with m_last on the final word.
// A 2-entry FIFO absorbs backpressure; an address is only issued when the
// word it will return is guaranteed a free buffer slot.
// Optional feature: define RD_STREAM_CHECKSUM_EN to add a running XOR
// checksum output of the words accepted in the current burst.
module ram_read_streamer #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   length,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               busy,
    output logic               done
`ifdef RD_STREAM_CHECKSUM_EN
    ,
    output logic [D_WIDTH-1:0] checksum
`endif
);

    localparam logic [A_WIDTH:0] DEPTH = {1'b1, {A_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [A_WIDTH-1:0] addr_reg;
    logic [A_WIDTH:0]   remaining_reg;
    logic               inflight_reg;       // an address was sampled by the RAM at the last edge
    logic               inflight_last_reg;  // ...and it was the final address of the burst
    logic               done_reg;

    logic [D_WIDTH-1:0] buf_data [2];
    logic               buf_last [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;

    logic               accept;
    logic               pop;
    logic               issue;
    logic               issue_last;
    logic               head_last;
    logic               done_set;
    logic [A_WIDTH:0]   len_sat;
    logic [2:0]         occupancy;

    // Handshake, saturation and issue-permission decode
    always_comb begin
        accept    = (state_reg == IDLE) && start;
        len_sat   = (length > DEPTH) ? DEPTH : length;
        pop       = m_valid && m_ready;
        head_last = buf_last[rd_ptr_reg];
        // Slots that will be occupied after this edge, ignoring a new issue.
        occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        issue      = (state_reg == RUN) && (occupancy <= 3'd1);
        issue_last = issue && (remaining_reg == {{A_WIDTH{1'b0}}, 1'b1});
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && (len_sat != '0)) state_next = RUN;
            RUN:     if (issue_last) state_next = DRAIN;
            DRAIN:   if (pop && head_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy level and the completion strobe request
    always_comb begin
        busy     = (state_reg != IDLE);
        done_set = (accept && (len_sat == '0)) ||
                   ((state_reg == DRAIN) && pop && head_last);
    end

    // Address generation, remaining count and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg          <= done_set;
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
            if (accept) begin
                addr_reg      <= base_addr;
                remaining_reg <= len_sat;
            end else if (issue) begin
                addr_reg      <= addr_reg + A_WIDTH'(1);
                remaining_reg <= remaining_reg - (A_WIDTH + 1)'(1);
            end
        end
    end

    // Buffer entries: each slot captures the RAM word when the write pointer selects it
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_data[gi] <= '0;
                    buf_last[gi] <= 1'b0;
                end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
                    buf_data[gi] <= data_read;
                    buf_last[gi] <= inflight_last_reg;
                end
            end
        end
    endgenerate

    // Buffer pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

`ifdef RD_STREAM_CHECKSUM_EN
    logic [D_WIDTH-1:0] checksum_reg;

    // Running XOR of accepted words, restarted on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg ^ m_data;
        end
    end

    assign checksum = checksum_reg;
`endif

    assign address_read = addr_reg;
    assign m_valid      = (count_reg != 2'd0);
    assign m_data       = buf_data[rd_ptr_reg];
    assign m_last       = m_valid && head_last;
    assign done         = done_reg;

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench for ram_read_streamer: a behavioural RAM with registered read,
// directed bursts, and a scoreboard queue drained by an independent monitor.
module tb_ram_read_streamer;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] address_read;
    logic [DW-1:0] data_read = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
`ifdef RD_STREAM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    ram_read_streamer #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .address_read(address_read),
        .data_read(data_read),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .done(done)
`ifdef RD_STREAM_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read, mem[i] = A000 + i
    logic [DW-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    always @(posedge clk) data_read <= mem[address_read];

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_popped = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented word to the queue head, pops on handshake
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %h, expected no word", m_data);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_q[0].d));
                check("m_last", 32'(m_last), 32'(exp_q[0].last));
                if (m_ready) begin
                    $display("beat %0d: data %h last %b", n_popped, m_data, m_last);
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    // Issue one start pulse and queue the expected words
    task automatic start_burst(input int b, input int len);
        int n;
        n = (len > 32) ? 32 : len;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d    = 16'hA000 + 16'((b + i) % 32);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        base_addr = AW'(b);
        length    = (AW + 1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("start base=%0d length=%0d", b, len);
        if (n != 0) begin
            check("start_addr", 32'(address_read), 32'(b));
            check("start_busy", 32'(busy), 32'd1);
        end
    endtask

    // Wait for done with a cycle budget; returns edges waited
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int k;

        // Reset state
        #2;
        check("rst_addr", 32'(address_read), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst with timing
        m_ready = 1'b1;
        start_burst(3, 4);
        check("t1_valid_e0", 32'(m_valid), 0);
        @(posedge clk); #1;
        check("t1_valid_e1", 32'(m_valid), 0);
        @(posedge clk); #1;
        check("t1_valid_e2", 32'(m_valid), 1);
        wait_done(20, cyc);
        check("t1_done_cycle", 32'(cyc), 32'd4);
        check("t1_busy_at_done", 32'(busy), 0);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done), 0);
        check("t1_drained", 32'(exp_q.size()), 0);

        // Wraparound and saturation
        start_burst(30, 4);
        wait_done(20, cyc);
        check("t2_drained", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        start_burst(30, 40);
        wait_done(100, cyc);
        check("t2_sat_drained", 32'(exp_q.size()), 0);
        @(posedge clk); #1;

        // Backpressure: alternating ready, then a long stall
        k = n_popped;
        m_ready = 1'b0;
        start_burst(0, 8);
        for (int i = 0; i < 6; i++) begin
            m_ready = i[0];
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 4 || i == 10) begin
                int got;
                got = n_popped - k;
                check("t3_addr_frozen", 32'(address_read),
                      32'((got + 2 > 8) ? 8 : got + 2));
                check("t3_valid_stall", 32'(m_valid), 1);
            end
        end
        cyc = n_popped - k;
        m_ready = 1'b1;
        begin
            int c2;
            wait_done(40, c2);
            check("t3_no_gaps", 32'(c2), 32'(8 - cyc));
        end
        check("t3_drained", 32'(exp_q.size()), 0);
        @(posedge clk); #1;

        // Zero length
        start_burst(7, 0);
        check("t4_done_zero", 32'(done), 1);
        check("t4_busy_zero", 32'(busy), 0);
        @(posedge clk); #1;
        check("t4_done_pulse", 32'(done), 0);
        @(posedge clk); #1;

        // Start while busy is ignored
        start_burst(10, 3);
        base_addr = 5'd20;
        length    = 6'd5;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(30, cyc);
        check("t5_drained", 32'(exp_q.size()), 0);
        @(posedge clk); #1;

        // Reset mid-burst
        k = n_popped;
        start_burst(0, 8);
        cyc = 0;
        while ((n_popped - k) < 2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_two_beats", 32'(n_popped - k), 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_addr", 32'(address_read), 0);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_data", 32'(m_data), 0);
        check("t6_rst_last", 32'(m_last), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_burst(5, 2);
        wait_done(20, cyc);
        check("t6_drained", 32'(exp_q.size()), 0);
        @(posedge clk); #1;

`ifdef RD_STREAM_CHECKSUM_EN
        start_burst(1, 4);
        wait_done(20, cyc);
        check("t7_checksum", 32'(checksum), 32'h0004);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
